// File: rtl/fu_dispatch_demux.sv
// Issue-to-FU demultiplexer: steers each accepted packet into one per-lane circular FIFO.
// Optional statistics counters are enabled with `define DEMUX_STATS_EN.
module fu_dispatch_demux #(
    parameter int NUM_FU = 3,
    parameter int PKT_W  = 64,
    parameter int DEPTH  = 2,
    localparam int LANE_W = $clog2(NUM_FU)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [LANE_W-1:0]       in_lane,
    input  logic [PKT_W-1:0]        in_pkt,
    output logic                    in_ready,
    output logic                    lane_err,
    output logic [NUM_FU-1:0]       out_valid,
    output logic [NUM_FU*PKT_W-1:0] out_pkt,
    input  logic [NUM_FU-1:0]       out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_FU*32-1:0]    stat_disp,
    output logic [31:0]             stat_stall
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_N = 1 << LANE_W;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic             lane_ok;
    logic [SEL_N-1:0] lane_full;
    logic             lane_err_reg;

    assign lane_ok = ({1'b0, in_lane} < (LANE_W + 1)'(NUM_FU));

    // Unused index codes read as permanently full, which also rejects invalid lanes.
    assign in_ready = reset_n & ~flush & ~lane_full[in_lane];
    assign lane_err = lane_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_lane
            logic [PKT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             push;
            logic             pop;

            assign push = in_valid & in_ready & (in_lane == LANE_W'(gi));
            assign pop  = (count_reg != '0) & out_ready[gi];

            assign lane_full[gi]                = (count_reg == CNT_W'(DEPTH));
            assign out_valid[gi]                = (count_reg != '0);
            assign out_pkt[gi*PKT_W +: PKT_W]   = mem[rd_ptr_reg];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push)
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    if (pop)
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    case ({push, pop})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Storage carries no reset; push already excludes flush through in_ready.
            always_ff @(posedge clk) begin
                if (push)
                    mem[wr_ptr_reg] <= in_pkt;
            end

`ifdef DEMUX_STATS_EN
            logic [31:0] disp_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    disp_reg <= '0;
                else if (push && (disp_reg != '1))
                    disp_reg <= disp_reg + 32'd1;
            end

            assign stat_disp[gi*32 +: 32] = disp_reg;
`endif
        end

        for (gi = NUM_FU; gi < SEL_N; gi++) begin : g_pad
            assign lane_full[gi] = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lane_err_reg <= 1'b0;
        else
            lane_err_reg <= in_valid & ~lane_ok;
    end

`ifdef DEMUX_STATS_EN
    logic [31:0] stall_reg;

    // Only stalls on a legal lane count; invalid lanes and flush cycles are excluded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_reg <= '0;
        else if (in_valid && !in_ready && lane_ok && !flush && (stall_reg != '1))
            stall_reg <= stall_reg + 32'd1;
    end

    assign stat_stall = stall_reg;
`endif

endmodule

// File: tb/tb_fu_dispatch_demux.sv
// Directed bench for fu_dispatch_demux: reset, steering, full/back-pressure, wrap, flush,
// invalid lane and async reset; a DEPTH=3 instance covers pointer wrap.
module tb_fu_dispatch_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic [1:0]   in_lane;
    logic [63:0]  in_pkt;
    logic         in_ready;
    logic         lane_err;
    logic [2:0]   out_valid;
    logic [191:0] out_pkt;
    logic [2:0]   out_ready;

    logic         in_valid3;
    logic [63:0]  in_pkt3;
    logic         in_ready3;
    logic         lane_err3;
    logic [2:0]   out_valid3;
    logic [191:0] out_pkt3;
    logic [2:0]   out_ready3;

`ifdef DEMUX_STATS_EN
    logic [95:0]  stat_disp;
    logic [31:0]  stat_stall;
    logic [95:0]  stat_disp3;
    logic [31:0]  stat_stall3;
`endif

    fu_dispatch_demux #(.NUM_FU(3), .PKT_W(64), .DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_lane   (in_lane),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .lane_err  (lane_err),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
        ,
        .stat_disp (stat_disp),
        .stat_stall(stat_stall)
`endif
    );

    fu_dispatch_demux #(.NUM_FU(3), .PKT_W(64), .DEPTH(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .in_valid  (in_valid3),
        .in_lane   (2'd0),
        .in_pkt    (in_pkt3),
        .in_ready  (in_ready3),
        .lane_err  (lane_err3),
        .out_valid (out_valid3),
        .out_pkt   (out_pkt3),
        .out_ready (out_ready3)
`ifdef DEMUX_STATS_EN
        ,
        .stat_disp (stat_disp3),
        .stat_stall(stat_stall3)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane_pkt(input int i);
        return out_pkt[i*64 +: 64];
    endfunction

    initial begin
        #90000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int recv;

        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_lane    = 2'd0;
        in_pkt     = 64'h11;
        out_ready  = 3'b111;
        in_valid3  = 1'b0;
        in_pkt3    = '0;
        out_ready3 = 3'b000;
        step();

        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_in_ready",  64'(in_ready),  64'(0));
            check("rst_lane_err",  64'(lane_err),  64'(0));
            step();
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #2;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));

        // Steering A->0, B->2, C->1
        step();
        in_valid = 1'b1; in_lane = 2'd0; in_pkt = 64'hAAAA;
        #2;
        check("steer_A_ready", 64'(in_ready), 64'(1));
        check("steer_no_bypass", 64'(out_valid), 64'(0));
        step();
        in_lane = 2'd2; in_pkt = 64'hBBBB;
        #2;
        check("steer_A_valid", 64'(out_valid), 64'(3'b001));
        check("steer_A_pkt", lane_pkt(0), 64'hAAAA);
        step();
        in_lane = 2'd1; in_pkt = 64'hCCCC;
        #2;
        check("steer_B_valid", 64'(out_valid), 64'(3'b100));
        check("steer_B_pkt", lane_pkt(2), 64'hBBBB);
        step();
        in_valid = 1'b0;
        #2;
        check("steer_C_valid", 64'(out_valid), 64'(3'b010));
        check("steer_C_pkt", lane_pkt(1), 64'hCCCC);
        step();
        #2;
        check("steer_drained", 64'(out_valid), 64'(0));

        // Invalid lane for 2 cycles
        in_valid = 1'b1; in_lane = 2'd3; in_pkt = 64'hDEAD;
        #2;
        check("bad_lane_ready0", 64'(in_ready), 64'(0));
        check("bad_lane_err0",   64'(lane_err), 64'(0));
        step();
        #2;
        check("bad_lane_ready1", 64'(in_ready), 64'(0));
        check("bad_lane_err1",   64'(lane_err), 64'(1));
        step();
        in_valid = 1'b0; in_lane = 2'd0;
        #2;
        check("bad_lane_err2", 64'(lane_err), 64'(1));
        step();
        #2;
        check("bad_lane_err3", 64'(lane_err), 64'(0));
        check("bad_lane_none", 64'(out_valid), 64'(0));
`ifdef DEMUX_STATS_EN
        check("stat_stall_bad", 64'(stat_stall), 64'(0));
        check("stat_disp0", 64'(stat_disp[31:0]),  64'(1));
        check("stat_disp1", 64'(stat_disp[63:32]), 64'(1));
        check("stat_disp2", 64'(stat_disp[95:64]), 64'(1));
`endif

        // Full lane 1 with back-pressure
        out_ready = 3'b000;
        in_valid = 1'b1; in_lane = 2'd1; in_pkt = 64'hF1;
        #2;
        check("full_P1_ready", 64'(in_ready), 64'(1));
        step();
        in_pkt = 64'hF2;
        #2;
        check("full_P2_ready", 64'(in_ready), 64'(1));
        step();
        in_pkt = 64'hF3;
        #2;
        check("full_P3_ready", 64'(in_ready), 64'(0));
        check("full_head_P1", lane_pkt(1), 64'hF1);
        step();
        out_ready = 3'b010;
        #2;
        check("full_pop_same_cycle", 64'(in_ready), 64'(0));
        check("full_head_P1b", lane_pkt(1), 64'hF1);
        step();
        #2;
        check("full_ready_next", 64'(in_ready), 64'(1));
        check("full_head_P2", lane_pkt(1), 64'hF2);
        step();
        in_valid = 1'b0;
        #2;
        check("full_valid_P3", 64'(out_valid), 64'(3'b010));
        check("full_head_P3", lane_pkt(1), 64'hF3);
        step();
        #2;
        check("full_drained", 64'(out_valid), 64'(0));
`ifdef DEMUX_STATS_EN
        check("stat_stall_full", 64'(stat_stall), 64'(2));
        check("stat_disp1_full", 64'(stat_disp[63:32]), 64'(4));
`endif

        // Flush with lanes holding 1/2/1
        out_ready = 3'b000;
        in_valid = 1'b1; in_lane = 2'd0; in_pkt = 64'h50;
        step();
        in_lane = 2'd1; in_pkt = 64'h51;
        step();
        in_pkt = 64'h52;
        step();
        in_lane = 2'd2; in_pkt = 64'h53;
        step();
        flush = 1'b1; in_lane = 2'd0; in_pkt = 64'h99;
        #2;
        check("flush_pre_valid", 64'(out_valid), 64'(3'b111));
        check("flush_in_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 3'b111;
        #2;
        check("flush_valid", 64'(out_valid), 64'(0));
        step();
        #2;
        check("flush_stays_empty", 64'(out_valid), 64'(0));
        in_valid = 1'b1; in_lane = 2'd0; in_pkt = 64'h77;
        step();
        in_valid = 1'b0;
        #2;
        check("flush_repush_valid", 64'(out_valid), 64'(3'b001));
        check("flush_repush_pkt", lane_pkt(0), 64'h77);
        step();
        #2;
        check("flush_repush_drain", 64'(out_valid), 64'(0));
`ifdef DEMUX_STATS_EN
        check("stat_disp0_flush", 64'(stat_disp[31:0]), 64'(3));
        check("stat_stall_flush", 64'(stat_stall), 64'(2));
`endif

        // Wrap on the DEPTH=3 instance, out_ready[0] toggling
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            out_ready3 = {2'b11, 1'((cyc & 1) != 0)};
            in_valid3  = (sent < 10);
            in_pkt3    = 64'(sent);
            #2;
            if (out_valid3[0] && out_ready3[0]) begin
                check("wrap_pkt", out_pkt3[63:0], 64'(recv));
                recv++;
            end
            if (in_valid3 && in_ready3)
                sent++;
            step();
        end
        in_valid3 = 1'b0;
        #2;
        check("wrap_count", 64'(recv), 64'(10));
        check("wrap_empty", 64'(out_valid3), 64'(0));

        // Asynchronous reset mid-cycle discards buffered data
        out_ready = 3'b000;
        in_valid = 1'b1; in_lane = 2'd2; in_pkt = 64'h42;
        step();
        in_valid = 1'b0;
        #2;
        check("async_pre_valid", 64'(out_valid), 64'(3'b100));
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_ready", 64'(in_ready), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
